// File: rtl/count_event_fifo.sv
// count_event_fifo
// Timestamps external trigger edges and counter wrap-arounds (MAX -> 0)
// with the current counter value and buffers them in a small FIFO that a
// consumer drains over a valid/ready interface. Dropped events (FIFO full,
// no concurrent pop) are reported through a sticky overflow flag and a
// saturating drop counter.
//
// Entry layout: {is_wrap, is_trig, value[WIDTH-1:0]}.
//
// Reset is applied asynchronously and is expected to be released
// synchronously to clk by the surrounding reset network.

module count_event_fifo #(
  parameter int WIDTH       = 4,
  parameter int DEPTH       = 8,   // power of two, >= 2
  parameter int SYNC_STAGES = 2    // >= 2
) (
  input  logic                     clk,
  input  logic                     rst,        // active-low
  input  logic [WIDTH-1:0]         count,
  input  logic                     trig,
  input  logic                     clear,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [WIDTH+1:0]         out_data,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     overflow,
  output logic [7:0]               drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam int EW = WIDTH + 2;

  localparam logic [FW-1:0]    FULL_LEVEL = FW'(DEPTH);
  localparam logic [WIDTH-1:0] COUNT_MAX  = '1;
  localparam logic [7:0]       DROP_SAT   = 8'hFF;

  // ---------------------------------------------------------------------------
  // Trigger path: synchronizer, then a registered rising-edge pulse.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   trig_s;
  logic                   trig_last;
  logic                   trig_evt;

  assign trig_s = sync_q[SYNC_STAGES-1];

  // Shift the asynchronous trig through the synchronizer chain.
  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour; blocking here would
  // collapse the chain into a single stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], trig};
    end
  end

  // Edge detect on the synchronized level; trig_evt is a one-cycle pulse.
  // Clearing trig_last in reset makes a trig held across release count once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trig_last <= 1'b0;
      trig_evt  <= 1'b0;
    end else begin
      trig_last <= trig_s;
      trig_evt  <= trig_s & ~trig_last;
    end
  end

  // ---------------------------------------------------------------------------
  // Wrap detect: MAX in the previous cycle followed by 0 in this one.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] prev_count;
  logic             prev_valid;
  logic             wrap_evt;

  // Remember last cycle's count; prev_valid masks the first cycle after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_count <= '0;
      prev_valid <= 1'b0;
    end else begin
      prev_count <= count;
      prev_valid <= 1'b1;
    end
  end

  assign wrap_evt = prev_valid && (prev_count == COUNT_MAX) && (count == '0);

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  logic [EW-1:0] entry;
  logic          push;
  logic          pop;
  logic          full;
  logic          push_ok;
  logic          drop;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [FW-1:0] fill_nxt;

  logic [EW-1:0] mem [DEPTH];

  // Simultaneous trigger and wrap share one entry with both flags set.
  assign entry = {wrap_evt, trig_evt, count};

  assign push      = trig_evt | wrap_evt;
  assign out_valid = (fill != '0);
  assign full      = (fill == FULL_LEVEL);
  // A pop while empty is impossible because pop is qualified by out_valid.
  assign pop       = out_valid & out_ready;
  // When full, a concurrent pop frees the slot the push lands in.
  assign push_ok   = push & (~full | pop);
  assign drop      = push & full & ~pop;

  // Storage array write port.
  // NOTE: the entry storage has no reset; emptiness is defined solely by
  // fill and the pointers, and out_data is forced to zero while empty, so
  // stale contents are never visible and the array can map to plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= entry;
    end
  end

  // Pointer update; both wrap naturally modulo DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Next occupancy from the accepted push and the pop of this cycle.
  // NOTE: every variable assigned in a combinational block gets a default
  // first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    fill_nxt = fill;
    case ({push_ok, pop})
      2'b10:   fill_nxt = fill + FW'(1);
      2'b01:   fill_nxt = fill - FW'(1);
      default: fill_nxt = fill;
    endcase
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill <= '0;
    end else begin
      fill <= fill_nxt;
    end
  end

  // First-word fall-through head; zero while empty.
  assign out_data = out_valid ? mem[rd_ptr] : '0;

  // ---------------------------------------------------------------------------
  // Debug status: sticky overflow and saturating drop counter.
  // clear is applied first, so a drop in the same cycle still registers.
  // ---------------------------------------------------------------------------
  logic       overflow_nxt;
  logic [7:0] drop_nxt;

  // Compute the next status values: clear, then account for a drop.
  always_comb begin
    overflow_nxt = overflow;
    drop_nxt     = drop_cnt;
    if (clear) begin
      overflow_nxt = 1'b0;
      drop_nxt     = '0;
    end
    if (drop) begin
      overflow_nxt = 1'b1;
      if (drop_nxt != DROP_SAT) drop_nxt = drop_nxt + 8'd1;
    end
  end

  // Status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      overflow <= overflow_nxt;
      drop_cnt <= drop_nxt;
    end
  end

endmodule

// File: tb/tb_count_event_fifo.sv
// Self-checking bench for count_event_fifo.
// The reference model works per clock edge from the recorded input history:
// an event is logged SYNC_STAGES+1 edges after trig is first seen high, a
// wrap is logged when count goes 15 -> 0 between two post-reset edges, and
// the FIFO is a queue with drop accounting.

module tb_count_event_fifo;

  localparam int W = 4;
  localparam int D = 8;
  localparam int S = 2;
  localparam int HMAX = 4096;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] count = '0;
  logic         trig = 1'b0;
  logic         clear = 1'b0;
  logic         out_ready = 1'b0;
  logic         out_valid;
  logic [W+1:0] out_data;
  logic [3:0]   fill;
  logic         overflow;
  logic [7:0]   drop_cnt;

  always #5 clk = ~clk;

  count_event_fifo #(.WIDTH(W), .DEPTH(D), .SYNC_STAGES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .count     (count),
    .trig      (trig),
    .clear     (clear),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .fill      (fill),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [W+1:0] mq [$];
  bit           m_over;
  int           m_drop;
  int           edge_n;
  bit           trig_h [HMAX];
  logic [W-1:0] cnt_h  [HMAX];
  logic [W-1:0] cv;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_over = 1'b0;
    m_drop = 0;
    edge_n = 0;
  endtask

  // Advance the model by one clock edge using this cycle's inputs.
  task automatic model_edge(input logic [W-1:0] c, input logic t, input logic r, input logic cl);
    bit tev, wev, pop, drop;
    edge_n++;
    trig_h[edge_n] = t;
    cnt_h[edge_n]  = c;
    tev = (edge_n - S - 1 >= 1) && trig_h[edge_n - S - 1] &&
          !((edge_n - S - 2 >= 1) && trig_h[edge_n - S - 2]);
    wev = (edge_n >= 2) && (cnt_h[edge_n - 1] == 4'hF) && (c == 4'h0);
    pop  = (mq.size() != 0) && r;
    drop = 1'b0;
    if (pop) void'(mq.pop_front());
    if (tev || wev) begin
      if (mq.size() < D) mq.push_back({wev, tev, c});
      else drop = 1'b1;
    end
    if (cl) begin
      m_over = 1'b0;
      m_drop = 0;
    end
    if (drop) begin
      m_over = 1'b1;
      if (m_drop < 255) m_drop++;
    end
  endtask

  task automatic check_all();
    check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    check("out_data",  32'(out_data),  (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
    check("fill",      32'(fill),      32'(mq.size()));
    check("overflow",  32'(overflow),  32'(m_over));
    check("drop_cnt",  32'(drop_cnt),  32'(m_drop));
  endtask

  task automatic step(input logic [W-1:0] c, input logic t, input logic r, input logic cl);
    @(negedge clk);
    count = c; trig = t; out_ready = r; clear = cl;
    @(posedge clk);
    #1;
    model_edge(c, t, r, cl);
    check_all();
  endtask

  // Release reset at a falling edge and model the first edge after it.
  task automatic release_step(input logic [W-1:0] c, input logic t, input logic r);
    @(negedge clk);
    rst = 1'b1;
    count = c; trig = t; out_ready = r; clear = 1'b0;
    @(posedge clk);
    #1;
    model_edge(c, t, r, 1'b0);
    check_all();
  endtask

  task automatic tick(input logic t, input logic r, input logic cl);
    step(cv, t, r, cl);
    cv = cv + 4'd1;
  endtask

  initial begin
    model_reset();
    cv = '0;

    // Reset state
    #1;
    check_all();

    // 1: ramp 0..15 -> 0 with no trig; only the wrap is logged
    release_step(cv, 1'b0, 1'b1);
    cv = cv + 4'd1;
    for (int i = 1; i < 17; i++) tick(1'b0, 1'b1, 1'b0);
    check("t1_wrap_entry", 32'(out_data), 32'h20);
    while (cv != 4'd2) tick(1'b0, 1'b1, 1'b0);

    // 2: trig high 3 cycles, count = 5 at detection, no ready
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    check("t2_not_yet", 32'(out_valid), 32'd0);
    tick(1'b0, 1'b0, 1'b0);
    check("t2_valid", 32'(out_valid), 32'd1);
    check("t2_entry", 32'(out_data), 32'h15);
    check("t2_fill", 32'(fill), 32'd1);

    // 3: trig edge coincident with the 15 -> 0 wrap
    while (cv != 4'd13) tick(1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    check("t3_entry", 32'(out_data), 32'h30);
    check("t3_fill", 32'(fill), 32'd1);
    repeat (3) tick(1'b0, 1'b1, 1'b0);

    // 4: 10 events with no ready -> full, 2 drops; then clear
    for (int i = 0; i < 10; i++) begin
      step(4'(i + 1), 1'b1, 1'b0, 1'b0);
      step(4'(i + 1), 1'b0, 1'b0, 1'b0);
    end
    repeat (4) step(4'd11, 1'b0, 1'b0, 1'b0);
    check("t4_fill", 32'(fill), 32'd8);
    check("t4_overflow", 32'(overflow), 32'd1);
    check("t4_drops", 32'(drop_cnt), 32'd2);
    step(4'd11, 1'b0, 1'b0, 1'b1);
    check("t4_clr_overflow", 32'(overflow), 32'd0);
    check("t4_clr_drops", 32'(drop_cnt), 32'd0);
    check("t4_clr_fill", 32'(fill), 32'd8);

    // 5: push with concurrent pop while full -> no drop
    step(4'd12, 1'b1, 1'b0, 1'b0);
    step(4'd12, 1'b0, 1'b0, 1'b0);
    step(4'd12, 1'b0, 1'b0, 1'b0);
    step(4'd12, 1'b0, 1'b1, 1'b0);
    check("t5_fill", 32'(fill), 32'd8);
    check("t5_drops", 32'(drop_cnt), 32'd0);

    // Clear concurrent with a drop -> overflow = 1, drop_cnt = 1
    step(4'd13, 1'b1, 1'b0, 1'b0);
    repeat (3) step(4'd13, 1'b0, 1'b0, 1'b0);
    step(4'd14, 1'b1, 1'b0, 1'b0);
    step(4'd14, 1'b0, 1'b0, 1'b0);
    step(4'd14, 1'b0, 1'b0, 1'b0);
    step(4'd14, 1'b0, 1'b0, 1'b1);
    check("clr_drop_overflow", 32'(overflow), 32'd1);
    check("clr_drop_cnt", 32'(drop_cnt), 32'd1);

    // Drop counter saturation
    repeat (260) begin
      step(4'd9, 1'b1, 1'b0, 1'b0);
      step(4'd9, 1'b0, 1'b0, 1'b0);
    end
    repeat (3) step(4'd9, 1'b0, 1'b0, 1'b0);
    check("drop_saturate", 32'(drop_cnt), 32'd255);

    // Drain; order is checked against the model queue
    repeat (10) step(4'd9, 1'b0, 1'b1, 1'b0);
    check("drained", 32'(fill), 32'd0);

    // 6: randomized traffic
    cv = 4'($urandom);
    repeat (400) begin
      logic t, r, cl;
      t  = ($urandom_range(0, 3) == 0);
      r  = 1'($urandom_range(0, 1));
      cl = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 15) == 0) cv = 4'($urandom);
      tick(t, r, cl);
    end

    // 7: asynchronous reset mid-cycle with fill = 5
    repeat (10) step(4'd3, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(4'd3, 1'b1, 1'b0, 1'b0);
      step(4'd3, 1'b0, 1'b0, 1'b0);
    end
    repeat (3) step(4'd3, 1'b0, 1'b0, 1'b0);
    check("t7_fill_before", 32'(fill), 32'd5);
    #2;
    rst  = 1'b0;
    trig = 1'b1;
    #1;
    check("t7_rst_valid", 32'(out_valid), 32'd0);
    check("t7_rst_fill", 32'(fill), 32'd0);
    check("t7_rst_data", 32'(out_data), 32'd0);
    check("t7_rst_drops", 32'(drop_cnt), 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    release_step(4'd3, 1'b1, 1'b0);
    repeat (7) step(4'd3, 1'b1, 1'b0, 1'b0);
    check("t7_one_event_fill", 32'(fill), 32'd1);
    check("t7_one_event_data", 32'(out_data), 32'h13);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/count_event_fifo.md
Name: count_event_fifo

Overview:
- Sits directly downstream of the 4-bit free-running `counter`; consumes its `count` output.
- Timestamps external trigger events and counter wrap-arounds (MAX -> 0) and buffers them in a small FIFO.
- Presents the FIFO to a consumer over a valid/ready interface.
- Reports overflow and the number of dropped events for debug.

Parameters:
- WIDTH, 4, width of the `count` input and of the stored value field.
- DEPTH, 8, FIFO entries; must be a power of two and >= 2.
- SYNC_STAGES, 2, flip-flops in the `trig` synchronizer; must be >= 2.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-low reset. Asserts immediately; deassertion is synchronous to the design.
- count  input  WIDTH  counter value, synchronous to `clk`.
- trig  input  1  asynchronous event request; a rising edge logs one event.
- clear  input  1  synchronous; clears `overflow` and `drop_cnt`.
- out_ready  input  1  consumer accepts the head entry.
- out_valid  output  1  FIFO not empty.
- out_data  output  WIDTH+2  head entry, laid out as {is_wrap, is_trig, value[WIDTH-1:0]}.
- fill  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky; set when an event is dropped.
- drop_cnt  output  8  dropped-event count, saturating at 255.

Behaviour:
- Reset (`rst` = 0):
  - Flushes the FIFO and clears pointers.
  - Clears the synchronizer chain, edge-detect register, prev-count register and prev_valid.
  - Output values during/after reset: out_valid = 0, out_data = 0, fill = 0, overflow = 0, drop_cnt = 0.
  - Reset mid-operation discards all entries in the same instant. Nothing partial survives.
- Trigger path:
  - `trig` passes through SYNC_STAGES flops, then a one-flop edge detector.
  - trig_evt is a one-cycle pulse on 0->1 of the synchronized signal.
  - Latency: `trig` high before edge E0 -> trig_evt high in the cycle after edge E0+SYNC_STAGES. With default SYNC_STAGES = 2, the entry is written at edge E3.
  - A `trig` held high across reset release yields exactly one event.
- Wrap detect:
  - Register prev_count each cycle.
  - wrap_evt = prev_valid && prev_count == 2^WIDTH-1 && count == 0.
  - prev_valid is set one cycle after reset release; no false wrap on the first cycle.
- Entry formation:
  - value = current `count` in the event cycle.
  - trig_evt and wrap_evt in the same cycle produce a single entry with both flags set.
  - No entry is produced when neither event fires.
- FIFO:
  - push = trig_evt | wrap_evt.
  - pop = out_valid & out_ready.
  - out_data is driven from the head storage register (first-word fall-through): out_valid rises in the cycle after the write edge.
  - out_data holds stable while out_valid = 1 and out_ready = 0.
  - out_data = 0 when empty.
  - Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH. fill is tracked separately.
- Boundary conditions:
  - Push and pop in the same cycle when full: both accepted; fill stays at DEPTH; no drop.
  - Push when full without pop: entry dropped; overflow <= 1; drop_cnt increments (saturates at 255). Contents are unchanged.
  - Push and pop in the same cycle when empty: pop is ignored (out_valid = 0); the push is written.
  - out_ready while empty: no effect.
  - `clear` concurrent with a drop: the result is overflow = 1 and drop_cnt = 1 (clear first, then the drop).
  - `clear` does not affect FIFO contents.

Test Plan:
- Reset release, `count` ramping 0..15, no `trig`, `out_ready` = 1 -> exactly one entry {1,0,0000} after the 15->0 step. No entry on the first cycle after reset.
- `trig` pulsed high for 3 cycles while `count` = 5 at the detection cycle, `out_ready` = 0 -> single entry {0,1,0101}. out_valid rises 4 edges after `trig` rises. fill = 1.
- `trig` edge detected in the same cycle as the 15->0 wrap -> single entry {1,1,0000}. fill increments by 1.
- `out_ready` = 0, 10 events -> fill = 8, overflow = 1, drop_cnt = 2. Then `clear` -> overflow = 0, drop_cnt = 0, fill still 8.
- Full FIFO, push together with `out_ready` = 1 -> fill stays 8, drop_cnt unchanged. Drain order matches write order.
- `rst` asserted asynchronously mid-clock with fill = 5 -> out_valid and fill are 0 immediately, before the next edge. A `trig` held high across release logs exactly one event.
